mc_datapath: RTL and testbench

Multicycle, parametrised successor to the single-cycle LEGv8 datapath. It accepts one decoded instruction per valid/ready handshake and sequences it through EXEC, an optional MEM and WB states. It talks to data memory over a variable-latency req/ack port, where the old datapath assumed a fixed-latency array. It sits between the decode/control unit and the data-memory port of the CPU.

---
 rtl/mc_datapath_pkg.sv | 30 +++
 rtl/mc_regfile.sv | 49 ++++
 rtl/mc_datapath.sv | 245 ++++++++++++++++++++++++
 tb/tb_mc_datapath.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_datapath_pkg.sv
// Shared types for the multicycle LEGv8 datapath: FSM states, ALU opcodes,
// and the latched control bundle.
package mc_datapath_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_MEM,
      ST_WB
   } state_e;

   localparam logic [2:0] ALU_PASS_B = 3'b000;
   localparam logic [2:0] ALU_ADD    = 3'b010;
   localparam logic [2:0] ALU_SUB    = 3'b011;
   localparam logic [2:0] ALU_AND    = 3'b100;
   localparam logic [2:0] ALU_OR     = 3'b101;
   localparam logic [2:0] ALU_XOR    = 3'b110;

   typedef struct packed {
      logic       reg2loc;
      logic       alusrc;
      logic       memtoreg;
      logic       regwrite;
      logic       memwrite;
      logic       memread;
      logic       chooseimm;
      logic [2:0] aluop;
   } ctrl_t;

endpackage

// File: rtl/mc_regfile.sv
// Register file: REG_N x DATA_W, two read ports, one debug read port, one
// write port. The top register is hard-wired to zero on every read port.
module mc_regfile #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned REG_N  = 32,
   localparam int unsigned RW    = $clog2(REG_N)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [RW-1:0]     ra_a,
   input  logic [RW-1:0]     ra_b,
   input  logic [RW-1:0]     dbg_sel,
   input  logic              we,
   input  logic [RW-1:0]     wa,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] regs_q [REG_N];
   logic [DATA_W-1:0] regs_d [REG_N];

   function automatic logic [DATA_W-1:0] rd_reg(input logic [RW-1:0] a);
      return (a == RW'(REG_N - 1)) ? '0 : regs_q[a];
   endfunction

   // Write port: the zero register is never written.
   always_comb begin
      regs_d = regs_q;
      if (we && (wa != RW'(REG_N - 1)))
         regs_d[wa] = wd;
   end

   // Register storage with asynchronous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < REG_N; i++)
            regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rd_a     = rd_reg(ra_a);
   assign rd_b     = rd_reg(ra_b);
   assign dbg_data = rd_reg(dbg_sel);

endmodule

// File: rtl/mc_datapath.sv
// Multicycle LEGv8 datapath: IDLE -> EXEC -> [MEM] -> WB per instruction,
// variable-latency req/ack data-memory port.
// Optional MEM timeout: define MC_DATAPATH_MEM_TIMEOUT_EN.
module mc_datapath
   import mc_datapath_pkg::*;
#(
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned REG_N       = 32,
   parameter int unsigned D9_W        = 9,
   parameter int unsigned IMM_W       = 12,
   parameter int unsigned MEM_TIMEOUT = 16,
   localparam int unsigned RW         = $clog2(REG_N)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [RW-1:0]     Rd,
   input  logic [RW-1:0]     Rm,
   input  logic [RW-1:0]     Rn,
   input  logic [D9_W-1:0]   Daddr9,
   input  logic [IMM_W-1:0]  Imm12,
   input  logic              Reg2Loc,
   input  logic              ALUSrc,
   input  logic              MemToReg,
   input  logic              RegWrite,
   input  logic              MemWrite,
   input  logic              MemRead,
   input  logic              ChooseImm,
   input  logic [2:0]        ALUOp,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              done,
   output logic              err,
   output logic              zeroFlag,
   output logic              negFlag,
   output logic              ovfFlag,
   output logic              carryFlag,
   input  logic [RW-1:0]     dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   state_e            state_q, state_d;
   ctrl_t             ctrl_q, ctrl_d;
   logic [RW-1:0]     rd_q, rd_d, rm_q, rm_d, rn_q, rn_d;
   logic [D9_W-1:0]   d9_q, d9_d;
   logic [IMM_W-1:0]  imm_q, imm_d;
   logic [DATA_W-1:0] res_q, res_d, st_q, st_d, ld_q, ld_d;
   logic              z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d;
   logic              wb_err;

`ifdef MC_DATAPATH_MEM_TIMEOUT_EN
   localparam int unsigned CW = $clog2(MEM_TIMEOUT) + 1;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              err_q, err_d;
   assign wb_err = err_q;
`else
   assign wb_err = 1'b0;
`endif

   logic [DATA_W-1:0] rf_a, rf_b, op_b, b_add, alu_res, wb_data;
   logic [DATA_W:0]   sum;
   logic [RW-1:0]     rb_addr;
   logic              is_sub, alu_c, alu_v, wb_we;

   // Port B reads Rd straight off the input while idle so store data can be
   // latched at accept; nothing writes the file between accept and EXEC.
   assign rb_addr = (state_q == ST_IDLE) ? Rd : (ctrl_q.reg2loc ? rm_q : rd_q);
   assign wb_we   = (state_q == ST_WB) && ctrl_q.regwrite && !wb_err;
   assign wb_data = ctrl_q.memtoreg ? ld_q : res_q;

   mc_regfile #(.DATA_W(DATA_W), .REG_N(REG_N)) u_regfile (
      .clk      (clk),
      .reset_n  (reset_n),
      .ra_a     (rn_q),
      .ra_b     (rb_addr),
      .dbg_sel  (dbg_sel),
      .we       (wb_we),
      .wa       (rd_q),
      .wd       (wb_data),
      .rd_a     (rf_a),
      .rd_b     (rf_b),
      .dbg_data (dbg_data)
   );

   // Operand B selection and ALU with add/sub carry and overflow.
   always_comb begin
      op_b = ctrl_q.chooseimm ? {{(DATA_W-IMM_W){1'b0}}, imm_q}
           : (ctrl_q.alusrc   ? {{(DATA_W-D9_W){d9_q[D9_W-1]}}, d9_q} : rf_b);
      is_sub  = (ctrl_q.aluop == ALU_SUB);
      b_add   = is_sub ? ~op_b : op_b;
      sum     = {1'b0, rf_a} + {1'b0, b_add} + {{DATA_W{1'b0}}, is_sub};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (ctrl_q.aluop)
         ALU_PASS_B: alu_res = op_b;
         ALU_ADD, ALU_SUB: begin
            alu_res = sum[DATA_W-1:0];
            alu_c   = sum[DATA_W];
            alu_v   = (rf_a[DATA_W-1] == b_add[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != rf_a[DATA_W-1]);
         end
         ALU_AND:    alu_res = rf_a & op_b;
         ALU_OR:     alu_res = rf_a | op_b;
         ALU_XOR:    alu_res = rf_a ^ op_b;
         default:    alu_res = '0;
      endcase
   end

   // Next-state and datapath register updates.
   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      rd_d    = rd_q;
      rm_d    = rm_q;
      rn_d    = rn_q;
      d9_d    = d9_q;
      imm_d   = imm_q;
      res_d   = res_q;
      st_d    = st_q;
      ld_d    = ld_q;
      z_d     = z_q;
      n_d     = n_q;
      v_d     = v_q;
      c_d     = c_q;
`ifdef MC_DATAPATH_MEM_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               ctrl_d  = '{reg2loc: Reg2Loc, alusrc: ALUSrc, memtoreg: MemToReg,
                           regwrite: RegWrite, memwrite: MemWrite, memread: MemRead,
                           chooseimm: ChooseImm, aluop: ALUOp};
               rd_d    = Rd;
               rm_d    = Rm;
               rn_d    = Rn;
               d9_d    = Daddr9;
               imm_d   = Imm12;
               st_d    = rf_b;
               ld_d    = '0;
`ifdef MC_DATAPATH_MEM_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            res_d   = alu_res;
            z_d     = (alu_res == '0);
            n_d     = alu_res[DATA_W-1];
            c_d     = alu_c;
            v_d     = alu_v;
`ifdef MC_DATAPATH_MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = (ctrl_q.memread || ctrl_q.memwrite) ? ST_MEM : ST_WB;
         end
         ST_MEM: begin
            if (mem_ack) begin
               if (ctrl_q.memread && !ctrl_q.memwrite)
                  ld_d = mem_rdata;
               state_d = ST_WB;
            end
`ifdef MC_DATAPATH_MEM_TIMEOUT_EN
            else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = ST_WB;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         ST_WB: begin
`ifdef MC_DATAPATH_MEM_TIMEOUT_EN
            err_d   = 1'b0;
`endif
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ctrl_q  <= '0;
         rd_q    <= '0;
         rm_q    <= '0;
         rn_q    <= '0;
         d9_q    <= '0;
         imm_q   <= '0;
         res_q   <= '0;
         st_q    <= '0;
         ld_q    <= '0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         v_q     <= 1'b0;
         c_q     <= 1'b0;
`ifdef MC_DATAPATH_MEM_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         rd_q    <= rd_d;
         rm_q    <= rm_d;
         rn_q    <= rn_d;
         d9_q    <= d9_d;
         imm_q   <= imm_d;
         res_q   <= res_d;
         st_q    <= st_d;
         ld_q    <= ld_d;
         z_q     <= z_d;
         n_q     <= n_d;
         v_q     <= v_d;
         c_q     <= c_d;
`ifdef MC_DATAPATH_MEM_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign in_ready  = (state_q == ST_IDLE) && reset_n;
   assign mem_req   = (state_q == ST_MEM);
   assign mem_we    = mem_req && ctrl_q.memwrite;
   assign mem_addr  = res_q;
   assign mem_wdata = st_q;
   assign done      = (state_q == ST_WB);
   assign err       = done && wb_err;
   assign zeroFlag  = z_q;
   assign negFlag   = n_q;
   assign ovfFlag   = v_q;
   assign carryFlag = c_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: stimulus pushes expectations computed by
// a plain-arithmetic reference model; a monitor checks each done pulse and
// the written register; a memory responder checks requests and acks.
module tb_mc_datapath;

   typedef struct packed {
      logic r2l, asrc, m2r, rw, mw, mr, ci;
      logic [2:0] op;
   } ic_t;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] val;
      logic        z, n, c, v, e;
      int          delta;
   } sb_t;

   typedef struct {
      logic        we;
      logic [63:0] addr, wdata, rdata;
      int          lat;
   } mx_t;

   logic        clk = 1'b0, reset_n = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [4:0]  Rd = '0, Rm = '0, Rn = '0, dbg_sel;
   logic [8:0]  Daddr9 = '0;
   logic [11:0] Imm12 = '0;
   logic        Reg2Loc = 0, ALUSrc = 0, MemToReg = 0, RegWrite = 0;
   logic        MemWrite = 0, MemRead = 0, ChooseImm = 0;
   logic [2:0]  ALUOp = '0;
   logic        mem_req, mem_we, mem_ack = 1'b0, done, err;
   logic [63:0] mem_addr, mem_wdata, mem_rdata = '0, dbg_data;
   logic        zeroFlag, negFlag, ovfFlag, carryFlag;

   sb_t         sbq[$];
   mx_t         mq[$];
   logic [63:0] model [32];
   int          n_pass = 0, n_total = 0, cyc = 0, last_acc = 0;
   logic        mon_pend = 1'b0;
   logic [4:0]  mon_sel = '0, stim_sel = '0;
   sb_t         mon_e;
   mx_t         mem_cur;
   logic        mem_active = 1'b0;
   int          mem_k = 0;

   assign dbg_sel = mon_pend ? mon_sel : stim_sel;

   mc_datapath #(.DATA_W(64), .REG_N(32), .D9_W(9), .IMM_W(12), .MEM_TIMEOUT(16)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .Rd(Rd), .Rm(Rm), .Rn(Rn), .Daddr9(Daddr9), .Imm12(Imm12),
      .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .MemRead(MemRead), .ChooseImm(ChooseImm), .ALUOp(ALUOp),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .done(done), .err(err),
      .zeroFlag(zeroFlag), .negFlag(negFlag), .ovfFlag(ovfFlag), .carryFlag(carryFlag),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic finish_run();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   endtask

   task automatic expire(input string nm);
      n_total++;
      $display("FAIL %s: wait bound expired", nm);
      finish_run();
   endtask

   function automatic logic [63:0] mr(input logic [4:0] r);
      return (r == 5'd31) ? 64'd0 : model[r];
   endfunction

   // Reference ALU from arithmetic definitions (signed range for overflow).
   task automatic alu_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                            output logic [63:0] r, output logic c, output logic v);
      logic [64:0]        w;
      logic signed [65:0] s, lim;
      lim = 66'sd1 <<< 63;
      c = 1'b0; v = 1'b0; r = '0;
      case (op)
         3'b000: r = b;
         3'b010: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[63:0]; c = w[64];
            s = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
            v = (s >= lim) || (s < -lim);
         end
         3'b011: begin
            r = a - b; c = (a >= b);
            s = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
            v = (s >= lim) || (s < -lim);
         end
         3'b100: r = a & b;
         3'b101: r = a | b;
         3'b110: r = a ^ b;
         default: r = '0;
      endcase
   endtask

   // Issue one instruction; lat = MEM cycle carrying the ack (0 = never acks).
   task automatic issue(input ic_t c, input logic [4:0] rd, input logic [4:0] rm,
                        input logic [4:0] rn, input logic [8:0] d9, input logic [11:0] imm,
                        input int lat, input logic [63:0] rdata, input bit linger,
                        input bit complete);
      logic [63:0] a, b, r, ld, dw;
      logic        cf, vf;
      bit          memop, to;
      sb_t         e;
      mx_t         m;
      int          t;
      a = mr(rn);
      b = c.ci ? {52'd0, imm} : (c.asrc ? {{55{d9[8]}}, d9} : mr(c.r2l ? rm : rd));
      alu_model(c.op, a, b, r, cf, vf);
      memop = c.mr || c.mw;
      to    = memop && (lat == 0);
      if (memop) begin
         m.we = c.mw; m.addr = r; m.wdata = mr(rd); m.rdata = rdata; m.lat = lat;
         mq.push_back(m);
      end
      if (complete) begin
         ld = (c.mr && !c.mw && !to) ? rdata : 64'd0;
         dw = c.m2r ? ld : r;
         if (c.rw && !to && rd != 5'd31) model[rd] = dw;
         e.rd = rd; e.val = mr(rd); e.z = (r == 0); e.n = r[63]; e.c = cf; e.v = vf;
         e.e = to; e.delta = 1 + (memop ? (to ? 16 : lat) : 0);
         sbq.push_back(e);
      end
      @(negedge clk);
      Rd = rd; Rm = rm; Rn = rn; Daddr9 = d9; Imm12 = imm;
      Reg2Loc = c.r2l; ALUSrc = c.asrc; MemToReg = c.m2r; RegWrite = c.rw;
      MemWrite = c.mw; MemRead = c.mr; ChooseImm = c.ci; ALUOp = c.op;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      if (!in_ready) expire("accept");
      @(posedge clk);
      @(negedge clk);
      last_acc = cyc;
      if (linger) begin
         chk("busy_in_ready", in_ready, 1'b0);
         Rd = 5'($urandom); Rn = 5'($urandom); RegWrite = 1'b1; ChooseImm = 1'b1;
         Imm12 = 12'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (complete) begin
         t = 0;
         while ((sbq.size() != 0 || mon_pend) && t < 100) begin @(negedge clk); t++; end
         if (sbq.size() != 0 || mon_pend) expire("done");
      end
   endtask

   // Monitor: checks each done pulse, then the destination register a cycle later.
   always @(negedge clk) begin
      if (!reset_n) begin
         mon_pend = 1'b0;
      end else begin
         if (mon_pend) begin
            chk("reg_value", dbg_data, mon_e.val);
            chk("ready_after_wb", in_ready, 1'b1);
            mon_pend = 1'b0;
         end
         if (done) begin
            if (sbq.size() == 0) begin
               chk("unexpected_done", done, 1'b0);
            end else begin
               mon_e = sbq.pop_front();
               chk("err", err, mon_e.e);
               chk("zeroFlag", zeroFlag, mon_e.z);
               chk("negFlag", negFlag, mon_e.n);
               chk("carryFlag", carryFlag, mon_e.c);
               chk("ovfFlag", ovfFlag, mon_e.v);
               chk("done_latency", 64'(cyc - last_acc), 64'(mon_e.delta));
               mon_sel  = mon_e.rd;
               mon_pend = 1'b1;
            end
         end
      end
   end

   // Memory responder: checks request fields every MEM cycle, acks on cycle lat.
   always @(negedge clk) begin
      mem_ack   = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (!reset_n) begin
         mem_active = 1'b0;
      end else if (mem_req) begin
         if (!mem_active) begin
            if (mq.size() == 0) begin
               chk("unexpected_mem_req", mem_req, 1'b0);
               mem_cur.we = mem_we; mem_cur.addr = mem_addr; mem_cur.wdata = mem_wdata;
               mem_cur.rdata = '0; mem_cur.lat = 0;
            end else begin
               mem_cur = mq.pop_front();
            end
            mem_active = 1'b1;
            mem_k = 1;
         end else begin
            mem_k++;
         end
         chk("mem_we", mem_we, mem_cur.we);
         chk("mem_addr", mem_addr, mem_cur.addr);
         chk("mem_wdata", mem_wdata, mem_cur.wdata);
         if (mem_cur.lat != 0 && mem_k == mem_cur.lat) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_cur.rdata;
         end
      end else begin
         mem_active = 1'b0;
      end
   end

   task automatic reg_expect(input logic [4:0] r, input logic [63:0] exp);
      @(negedge clk);
      stim_sel = r;
      #1;
      chk("reg_read", dbg_data, exp);
   endtask

   initial begin
      ic_t c;
      int  lat;
      for (int i = 0; i < 32; i++) model[i] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_flags", {zeroFlag, negFlag, ovfFlag, carryFlag}, 4'b0000);
      reset_n = 1'b1;
      #1;
      chk("post_rst_ready", in_ready, 1'b1);
      reg_expect(5'd0, 64'd0);

      // ADDI X0, X31, #69
      c = '0; c.ci = 1; c.op = 3'b010; c.rw = 1;
      issue(c, 5'd0, 5'd0, 5'd31, 9'd0, 12'd69, 0, 64'd0, 0, 1);
      // STUR X0, [X31, #8], ack on third MEM cycle
      c = '0; c.asrc = 1; c.mw = 1; c.op = 3'b010;
      issue(c, 5'd0, 5'd0, 5'd31, 9'd8, 12'd0, 3, 64'd0, 0, 1);
      // LDUR X30, [X31, #8], same-cycle ack
      c = '0; c.asrc = 1; c.mr = 1; c.m2r = 1; c.rw = 1; c.op = 3'b010;
      issue(c, 5'd30, 5'd0, 5'd31, 9'd8, 12'd0, 1, 64'd69, 0, 1);
      // SUB X1, X30, X0
      c = '0; c.r2l = 1; c.rw = 1; c.op = 3'b011;
      issue(c, 5'd1, 5'd0, 5'd30, 9'd0, 12'd0, 0, 64'd0, 0, 1);
      // ADDI X31, X31, #5 with in_valid held through EXEC
      c = '0; c.ci = 1; c.op = 3'b010; c.rw = 1;
      issue(c, 5'd31, 5'd0, 5'd31, 9'd0, 12'd5, 0, 64'd0, 1, 1);
      reg_expect(5'd31, 64'd0);
      // Load with negative offset from X0 into X2
      c = '0; c.asrc = 1; c.mr = 1; c.m2r = 1; c.rw = 1; c.op = 3'b010;
      issue(c, 5'd2, 5'd0, 5'd0, 9'h1F8, 12'd0, 2, 64'hDEAD_BEEF_0000_1234, 0, 1);
      // Seed a few registers with large immediates via OR
      for (int i = 3; i < 8; i++) begin
         c = '0; c.ci = 1; c.op = 3'b101; c.rw = 1;
         issue(c, 5'(i), 5'd0, 5'(i - 1), 9'd0, 12'($urandom), 0, 64'd0, 0, 1);
      end

      // Randomized instruction mix
      for (int i = 0; i < 60; i++) begin
         c = ic_t'($urandom);
         if ($urandom_range(0, 2) != 0) begin
            c.mr = 1'b0; c.mw = 1'b0;
         end else if (!c.mr && !c.mw) begin
            c.mr = 1'b1;
         end
         lat = $urandom_range(1, 4);
         issue(c, 5'($urandom), 5'($urandom), 5'($urandom), 9'($urandom), 12'($urandom),
               lat, {$urandom, $urandom}, 1'($urandom), 1);
      end

`ifdef MC_DATAPATH_MEM_TIMEOUT_EN
      // Load into X3 that never acks
      c = '0; c.asrc = 1; c.mr = 1; c.m2r = 1; c.rw = 1; c.op = 3'b010;
      issue(c, 5'd3, 5'd0, 5'd31, 9'd16, 12'd0, 0, 64'd0, 0, 1);
`endif

      // Reset asserted during MEM
      c = '0; c.asrc = 1; c.mr = 1; c.m2r = 1; c.rw = 1; c.op = 3'b010;
      issue(c, 5'd4, 5'd0, 5'd31, 9'd24, 12'd0, 0, 64'd0, 0, 0);
      begin
         int t = 0;
         while (!mem_req && t < 20) begin @(negedge clk); t++; end
         if (!mem_req) expire("mem_req_rise");
      end
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_mem_req", mem_req, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_in_ready", in_ready, 1'b0);
      repeat (2) begin
         @(negedge clk);
         chk("abort_done_hold", done, 1'b0);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 32; i++) model[i] = '0;
      chk("abort_flags", {zeroFlag, negFlag, ovfFlag, carryFlag}, 4'b0000);
      reg_expect(5'd0, 64'd0);
      reg_expect(5'd1, 64'd0);
      reg_expect(5'd30, 64'd0);
      repeat (3) @(negedge clk);
      chk("idle_after_abort", in_ready, 1'b1);

      finish_run();
   end

   initial begin
      #500000;
      expire("global_watchdog");
   end

endmodule
